// File: rtl/bounce_gen.sv
// -----------------------------------------------------------------------------
// bounce_gen
//
// Switch-bounce emulator. On request it drives signal_o through a burst of
// pseudo-random level changes at pseudo-random spacing. It then settles at the
// requested final level. A free-running 16-bit Galois LFSR supplies both the
// levels and the spacing, so a given SEED always reproduces the same trace.
//
// Parameters
//   N          width of the gap/settle counters and their limit inputs
//              (2..16; the gap mask is taken from the low N LFSR bits)
//   SEED       LFSR reset value (0 is replaced by 16'h0001)
//   RST_LEVEL  level of signal_o during and after reset
//
// Ports
//   sysclk         in   system clock, rising edge
//   reset_n        in   asynchronous active-low reset
//   start_i        in   request a burst; only looked at in IDLE
//   final_state_i  in   level to settle at (latched on accept)
//   n_bounces_i    in   random-level updates before the final one (latched)
//   max_gap_i      in   gap mask (latched)
//   settle_i       in   settle duration in cycles, 0 treated as 1 (latched)
//   signal_o       out  emulated switch output, registered
//   busy_o         out  high while a burst is running
//   done_o         out  one-cycle pulse when a burst completes
//   state_o        out  current FSM state (IDLE=0, BOUNCE=1, SETTLE=2)
//
// Handshake: a request is accepted on any rising edge where the FSM is IDLE
// and start_i=1. No back-pressure exists; requests outside IDLE are dropped
// rather than queued.
// -----------------------------------------------------------------------------
module bounce_gen #(
   parameter int          N         = 8,
   parameter logic [15:0] SEED      = 16'hACE1,
   parameter logic        RST_LEVEL = 1'b1
) (
   input  logic         sysclk,
   input  logic         reset_n,
   input  logic         start_i,
   input  logic         final_state_i,
   input  logic [7:0]   n_bounces_i,
   input  logic [N-1:0] max_gap_i,
   input  logic [N-1:0] settle_i,
   output logic         signal_o,
   output logic         busy_o,
   output logic         done_o,
   output logic [1:0]   state_o
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      BOUNCE = 2'd1,
      SETTLE = 2'd2
   } state_t;

   // An all-zero Galois LFSR never leaves zero, so a zero seed is remapped.
   localparam logic [15:0] SEED_L = (SEED == 16'h0000) ? 16'h0001 : SEED;
   localparam logic [15:0] POLY   = 16'hB400;
   localparam logic [N-1:0] ONE_N = {{(N-1){1'b0}}, 1'b1};

   state_t       state;
   logic [15:0]  lfsr;
   logic [7:0]   bounce_cnt;
   logic [N-1:0] gap_cnt;
   logic [N-1:0] settle_cnt;

   logic         final_l;
   logic [7:0]   n_bounces_l;
   logic [N-1:0] max_gap_l;
   logic [N-1:0] settle_l;

   logic [N-1:0] gap_first;   // gap for the accepting edge (mask not latched yet)
   logic [N-1:0] gap_next;    // gap for reloads inside a burst
   logic [N-1:0] settle_eff;

   assign state_o = state;

   // Free-running LFSR; it advances every cycle whatever the FSM does, so the
   // trace depends on how many cycles passed since reset before the start.
   always_ff @(posedge sysclk or negedge reset_n) begin
      if (!reset_n) begin
         lfsr <= SEED_L;
      end else if (lfsr[0]) begin
         lfsr <= (lfsr >> 1) ^ POLY;
      end else begin
         lfsr <= lfsr >> 1;
      end
   end

   // A masked value of zero becomes 1, so every gap lasts at least one cycle.
   always_comb begin
      gap_first  = lfsr[N-1:0] & max_gap_i;
      gap_next   = lfsr[N-1:0] & max_gap_l;
      settle_eff = settle_l;
      if (gap_first == '0) gap_first = ONE_N;
      if (gap_next == '0)  gap_next  = ONE_N;
      if (settle_l == '0)  settle_eff = ONE_N;
   end

   always_ff @(posedge sysclk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= IDLE;
         signal_o    <= RST_LEVEL;
         busy_o      <= 1'b0;
         done_o      <= 1'b0;
         bounce_cnt  <= 8'd0;
         gap_cnt     <= '0;
         settle_cnt  <= '0;
         final_l     <= 1'b0;
         n_bounces_l <= 8'd0;
         max_gap_l   <= '0;
         settle_l    <= '0;
      end else begin
         done_o <= 1'b0;
         case (state)
            IDLE: begin
               if (start_i) begin
                  final_l     <= final_state_i;
                  n_bounces_l <= n_bounces_i;
                  max_gap_l   <= max_gap_i;
                  settle_l    <= settle_i;
                  signal_o    <= ~final_state_i;
                  bounce_cnt  <= 8'd0;
                  gap_cnt     <= gap_first;
                  busy_o      <= 1'b1;
                  state       <= BOUNCE;
               end
            end
            BOUNCE: begin
               if (gap_cnt == ONE_N) begin
                  if (bounce_cnt < n_bounces_l) begin
                     signal_o   <= lfsr[15];
                     bounce_cnt <= bounce_cnt + 8'd1;
                     gap_cnt    <= gap_next;
                  end else begin
                     signal_o   <= final_l;
                     settle_cnt <= settle_eff;
                     state      <= SETTLE;
                  end
               end else begin
                  gap_cnt <= gap_cnt - ONE_N;
               end
            end
            SETTLE: begin
               if (settle_cnt == ONE_N) begin
                  busy_o <= 1'b0;
                  done_o <= 1'b1;
                  state  <= IDLE;
               end else begin
                  settle_cnt <= settle_cnt - ONE_N;
               end
            end
            default: begin
               state  <= IDLE;
               busy_o <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bounce_gen.sv
// -----------------------------------------------------------------------------
// tb_bounce_gen
//
// Directed bench for bounce_gen (N=8, SEED=16'hACE1, RST_LEVEL=1). The bench
// predicts each burst from its own copy of the LFSR. It builds the list of
// update times and levels, then the per-cycle {signal, busy, done} timeline.
// That timeline is pushed into exp_q when the start is driven and popped one
// entry per cycle.
// -----------------------------------------------------------------------------
module tb_bounce_gen;

   localparam int          N    = 8;
   localparam logic [15:0] SEED = 16'hACE1;

   logic         sysclk = 1'b0;
   logic         reset_n = 1'b1;
   logic         start_i = 1'b0;
   logic         final_state_i = 1'b0;
   logic [7:0]   n_bounces_i = 8'd0;
   logic [N-1:0] max_gap_i = '0;
   logic [N-1:0] settle_i = '0;
   logic         signal_o;
   logic         busy_o;
   logic         done_o;
   logic [1:0]   state_o;

   bounce_gen #(.N(N), .SEED(SEED), .RST_LEVEL(1'b1)) dut (
      .sysclk        (sysclk),
      .reset_n       (reset_n),
      .start_i       (start_i),
      .final_state_i (final_state_i),
      .n_bounces_i   (n_bounces_i),
      .max_gap_i     (max_gap_i),
      .settle_i      (settle_i),
      .signal_o      (signal_o),
      .busy_o        (busy_o),
      .done_o        (done_o),
      .state_o       (state_o)
   );

   // ---------------- clock / reset ----------------
   always #5 sysclk = ~sysclk;

   int total = 0;
   int bad   = 0;

   logic [2:0]  exp_q[$];
   int          upd_t[0:256];
   logic [15:0] tb_lfsr;

   function automatic logic [15:0] lstep(input logic [15:0] l);
      return l[0] ? ((l >> 1) ^ 16'hB400) : (l >> 1);
   endfunction

   function automatic int gapf(input logic [15:0] l, input logic [7:0] m);
      logic [7:0] g;
      g = l[7:0] & m;
      return (g == 8'd0) ? 1 : int'(g);
   endfunction

   // Reference LFSR: at a falling edge it holds the value the DUT will use at
   // the next rising edge.
   always @(posedge sysclk or negedge reset_n) begin
      if (!reset_n) tb_lfsr <= SEED;
      else          tb_lfsr <= lstep(tb_lfsr);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Build the expected timeline for a burst accepted at the next rising edge.
   // l0 is the LFSR value that edge sees. Entry j is the output after edge t0+j.
   task automatic predict(input logic [15:0] l0, input logic f, input logic [7:0] n,
                          input logic [7:0] mg, input logic [7:0] st);
      logic [15:0] l;
      logic        upd_v[0:256];
      int          t, g, tt;
      logic        sig;
      l = l0;
      t = 0;
      for (int k = 1; k <= int'(n) + 1; k++) begin
         g = gapf(l, mg);
         for (int s = 0; s < g; s++) l = lstep(l);
         t += g;
         upd_t[k] = t;
         upd_v[k] = (k <= int'(n)) ? l[15] : f;
      end
      tt = t + ((st == 8'd0) ? 1 : int'(st));
      for (int j = 0; j <= tt; j++) begin
         sig = ~f;
         for (int k = 1; k <= int'(n) + 1; k++)
            if (upd_t[k] <= j) sig = upd_v[k];
         exp_q.push_back({sig, (j < tt) ? 1'b1 : 1'b0, (j == tt) ? 1'b1 : 1'b0});
      end
   endtask

   // ---------------- driver tasks ----------------
   // Called at a falling edge; the request is taken at the following rising edge.
   task automatic start_burst(input logic f, input logic [7:0] n,
                              input logic [7:0] mg, input logic [7:0] st);
      start_i       = 1'b1;
      final_state_i = f;
      n_bounces_i   = n;
      max_gap_i     = mg;
      settle_i      = st;
      predict(tb_lfsr, f, n, mg, st);
   endtask

   // Walks the queued timeline one cycle at a time. A stray start is pulsed at
   // index pulse_at (-1 for none). Ends at the falling edge of the done cycle.
   task automatic run_burst(input string tag, input int pulse_at,
                            output int busy_cnt, output logic [31:0] h);
      logic [2:0] e;
      int j;
      busy_cnt = 0;
      h = 32'd0;
      j = 0;
      while (exp_q.size() > 0) begin
         @(negedge sysclk);
         start_i = (j == pulse_at);
         if (j == pulse_at) begin
            final_state_i = 1'($urandom_range(0, 1));
            n_bounces_i   = 8'($urandom_range(0, 255));
            max_gap_i     = 8'($urandom_range(0, 255));
            settle_i      = 8'($urandom_range(0, 255));
         end
         e = exp_q.pop_front();
         chk(tag, {29'd0, signal_o, busy_o, done_o}, {29'd0, e});
         busy_cnt += int'(busy_o);
         h = (h * 33) ^ {31'd0, signal_o};
         j++;
      end
      start_i = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge sysclk);
      start_i = 1'b0;
      reset_n = 1'b0;
      repeat (2) @(negedge sysclk);
      reset_n = 1'b1;
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      int          bc;
      logic [31:0] h1, h2, hx;
      int          u3;
      logic [2:0]  e;

      #1 reset_n = 1'b0;

      // Reset held: start_i toggling must not move anything.
      for (int i = 0; i < 4; i++) begin
         @(negedge sysclk);
         start_i = ~start_i;
         #1;
         chk("rst_hold", {29'd0, signal_o, busy_o, done_o}, 32'b100);
      end
      @(negedge sysclk);
      start_i = 1'b0;
      reset_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge sysclk);
         chk("rst_idle", {29'd0, signal_o, busy_o, done_o}, 32'b100);
      end
      chk("rst_state", {30'd0, state_o}, 32'd0);

      // Deterministic burst: unit gaps, 4 bounces, settle 10.
      start_burst(1'b0, 8'd4, 8'h00, 8'd10);
      run_burst("det", -1, bc, hx);
      chk("det_busy_cycles", bc, 32'd15);
      repeat (3) @(negedge sysclk);
      chk("det_idle_after", {29'd0, signal_o, busy_o, done_o}, 32'b000);

      // Zero case, then a new request during its done cycle.
      start_burst(1'b1, 8'd0, 8'h00, 8'd0);
      run_burst("zero", -1, bc, hx);
      chk("zero_busy_cycles", bc, 32'd2);
      start_burst(1'b0, 8'd2, 8'h03, 8'd4);
      run_burst("chain", -1, bc, hx);
      repeat (2) @(negedge sysclk);

      // Random gaps with a stray start mid-burst, repeated after reset.
      do_reset();
      repeat (3) @(negedge sysclk);
      start_burst(1'b1, 8'd20, 8'h0F, 8'd50);
      run_burst("rand1", 30, bc, h1);
      do_reset();
      repeat (3) @(negedge sysclk);
      start_burst(1'b1, 8'd20, 8'h0F, 8'd50);
      run_burst("rand2", 30, bc, h2);
      chk("rand_repeat_trace", h2, h1);

      // Async reset shortly after update 3 of a 10-bounce burst.
      repeat (2) @(negedge sysclk);
      start_burst(1'b0, 8'd10, 8'h07, 8'd20);
      u3 = upd_t[3];
      for (int j = 0; j <= u3; j++) begin
         @(negedge sysclk);
         start_i = 1'b0;
         e = exp_q.pop_front();
         chk("pre_abort", {29'd0, signal_o, busy_o, done_o}, {29'd0, e});
      end
      #2 reset_n = 1'b0;
      #1;
      chk("abort_now", {29'd0, signal_o, busy_o, done_o}, 32'b100);
      exp_q.delete();
      for (int i = 0; i < 3; i++) begin
         @(negedge sysclk);
         chk("abort_hold", {29'd0, signal_o, busy_o, done_o}, 32'b100);
      end
      reset_n = 1'b1;
      repeat (2) @(negedge sysclk);
      chk("abort_idle", {29'd0, signal_o, busy_o, done_o}, 32'b100);
      start_burst(1'b1, 8'd10, 8'h07, 8'd20);
      run_burst("post_abort", -1, bc, hx);

      repeat (2) @(negedge sysclk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Global time limit so the run always ends.
   initial begin
      #500000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "time limit");
   end

endmodule

// File: doc/bounce_gen.md
# bounce_gen

Synthesizable switch-bounce emulator: on request, drives a single-bit output through a burst of pseudo-random level changes with pseudo-random spacing, then settles at a requested final level. It sits in front of the debounce block in on-board self-test builds and replaces the mechanical switch as a repeatable, clock-accurate bounce source. Randomness comes from an internal free-running LFSR, so a given SEED always reproduces the same sequence.

## Interface
- N, 8, width of gap and settle counters and their limit inputs
- SEED, 16'hACE1, LFSR reset value; 0 is illegal and replaced by 16'h0001
- RST_LEVEL, 1'b1, value of signal_o during and after reset (switch idle level)

- sysclk  input  1  system clock; all logic on rising edge
- reset_n  input  1  asynchronous, active-low reset
- start_i  input  1  request a bounce burst; sampled only in IDLE
- final_state_i  input  1  level signal_o settles at; latched on accept
- n_bounces_i  input  8  number of random-level updates before the final update; latched
- max_gap_i  input  N  gap mask; latched
- settle_i  input  N  settle duration in cycles; latched
- signal_o  output  1  emulated bouncing switch, registered
- busy_o  output  1  high while a burst is in progress
- done_o  output  1  one-cycle pulse when a burst completes

## Operation
- Reset (async): signal_o=RST_LEVEL, busy_o=0, done_o=0, state=IDLE, LFSR=SEED, all counters 0.
- LFSR: 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1 (mask 16'hB400), advances every cycle out of reset regardless of state.
- Gap value: g = lfsr[N-1:0] & max_gap_l; if g==0 use 1. Range [1, max(max_gap_l,1)].
- States: IDLE, BOUNCE, SETTLE.
- IDLE: start_i=1 -> latch inputs, signal_o<=~final_state_i, bounce count<=0, gap counter<=g, busy_o<=1, go BOUNCE. Otherwise signal_o holds.
- BOUNCE: gap counter decrements each cycle; on the cycle it equals 1:
  - count < n_bounces_l: signal_o<=lfsr[15], count++, reload gap counter with new g.
  - count == n_bounces_l: signal_o<=final_state_l, settle counter<=max(settle_l,1), go SETTLE.
- SETTLE: signal_o holds final_state_l; settle counter decrements; on the cycle it equals 1: go IDLE, busy_o<=0, done_o<=1 for one cycle.
- start_i outside IDLE is ignored (not queued). start_i during the done_o cycle is accepted (state is IDLE).
- n_bounces_i=0: single gap, then final level; a legal burst.
- Counter widths: bounce count 8 bits, gap/settle counters N bits; no wrap possible given the limits above.
- Reset asserted mid-burst aborts immediately: no done_o, signal_o returns to RST_LEVEL.

## Timing
- Let t0 be the accepting edge. signal_o=~final and busy_o=1 are visible after t0.
- Update k (k=1..n_bounces) occurs at t0 + g1+...+gk; the final update one gap later, at tF.
- done_o high and busy_o low after edge tF+max(settle_l,1); signal_o never changes during SETTLE.
- Total busy cycles = sum of (n_bounces+1) gaps + max(settle_l,1).
- Earliest next accept: the done_o cycle.

## Test plan
- Reset: hold reset_n=0 with RST_LEVEL=1, toggle start_i -> signal_o=1, busy_o=0, done_o=0; release reset, idle 10 cycles -> outputs unchanged.
- Deterministic burst: max_gap=0, n_bounces=4, settle=10, final=0, N=8 -> signal_o=1 after t0; updates at t0+1..t0+4; signal_o=0 from t0+5; done_o pulse after t0+15; busy_o high exactly 15 cycles.
- Random gaps: max_gap=8'h0F, n_bounces=20, settle=50, final=1 -> 21 update edges, each spacing in [1,15]; last update sets 1; signal_o stable 50 cycles before done_o; rerun after reset gives identical trace (same SEED).
- Ignore/zero cases: n_bounces=0, max_gap=0, settle=0 -> final level at t0+1, done_o after t0+2; start_i pulsed during busy -> no effect; start_i in done_o cycle -> new burst starts.
- Async reset mid-BOUNCE: assert reset_n between clock edges at update 3 of 10 -> signal_o=RST_LEVEL, busy_o=0 immediately, no done_o; after release a new start runs a full burst correctly.
